// File: rtl/sprite_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_scheduler
//
// Per-frame sequencer that feeds sprite draw requests to the graphics engine.
// Game logic can write a MAX_SPRITES-entry sprite table at any time. Each
// change of frame_count starts a walk of the table in ascending slot order,
// which is painter's order: a higher slot draws on top. Every eligible entry
// is sent over the sprite_valid/sprite_ready handshake, with only one sprite
// in flight at a time.
//
// Optional feature: define SPRITE_CULL_EN to skip entries whose top-left
// corner lies outside the canvas. When it is undefined, every active entry
// is issued and coordinates pass through unchecked.
//
// Ports
//   clk_pixel           in   pixel clock, the only clock
//   sys_rst_n           in   asynchronous active-low reset
//   frame_count         in   video frame counter; any change is a frame boundary
//   wr_en               in   table write strobe
//   wr_slot             in   slot written
//   wr_active           in   valid bit written to the slot
//   wr_x / wr_y         in   sprite top-left corner
//   wr_frame            in   spritesheet frame number
//   sprite_ready        in   graphics engine idle / finished
//   sprite_valid        out  one-cycle draw request pulse
//   sprite_x / _y       out  request coordinates, held until the next request
//   sprite_frame_number out  request frame, held until the next request
//   busy                out  walk in progress
//   walk_done           out  one-cycle pulse when a walk completes
//   overrun             out  one-cycle pulse: frame boundary arrived while busy
//   sprites_issued      out  requests issued in the last completed walk
// ---------------------------------------------------------------------------
module sprite_scheduler #(
    parameter int MAX_SPRITES   = 16,
    parameter int CANVAS_WIDTH  = 360,
    parameter int CANVAS_HEIGHT = 720,
    parameter int NUM_FRAMES    = 18,
    localparam int SW = $clog2(MAX_SPRITES),
    localparam int XW = $clog2(CANVAS_WIDTH),
    localparam int YW = $clog2(CANVAS_HEIGHT),
    localparam int FW = $clog2(NUM_FRAMES)
) (
    input  logic          clk_pixel,
    input  logic          sys_rst_n,
    input  logic [5:0]    frame_count,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_slot,
    input  logic          wr_active,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  logic [FW-1:0] wr_frame,
    input  logic          sprite_ready,
    output logic          sprite_valid,
    output logic [XW-1:0] sprite_x,
    output logic [YW-1:0] sprite_y,
    output logic [FW-1:0] sprite_frame_number,
    output logic          busy,
    output logic          walk_done,
    output logic          overrun,
    output logic [SW:0]   sprites_issued
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_ACK,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [SW-1:0] LAST_SLOT = SW'(MAX_SPRITES - 1);

    // ---------------------------------------------------------------------
    // Sprite table: flops with a combinational read. A write lands at the
    // clock edge, so a scan of the same slot in that cycle sees old data.
    // ---------------------------------------------------------------------
    logic          tbl_active_q [MAX_SPRITES];
    logic          tbl_active_d [MAX_SPRITES];
    logic [XW-1:0] tbl_x_q      [MAX_SPRITES];
    logic [XW-1:0] tbl_x_d      [MAX_SPRITES];
    logic [YW-1:0] tbl_y_q      [MAX_SPRITES];
    logic [YW-1:0] tbl_y_d      [MAX_SPRITES];
    logic [FW-1:0] tbl_frame_q  [MAX_SPRITES];
    logic [FW-1:0] tbl_frame_d  [MAX_SPRITES];

    // NOTE: every always_comb variable gets a default first so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        tbl_active_d = tbl_active_q;
        tbl_x_d      = tbl_x_q;
        tbl_y_d      = tbl_y_q;
        tbl_frame_d  = tbl_frame_q;
        if (wr_en) begin
            tbl_active_d[wr_slot] = wr_active;
            tbl_x_d[wr_slot]      = wr_x;
            tbl_y_d[wr_slot]      = wr_y;
            tbl_frame_d[wr_slot]  = wr_frame;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < MAX_SPRITES; i++) begin
                tbl_active_q[i] <= 1'b0;
            end
        end else begin
            tbl_active_q <= tbl_active_d;
        end
    end

    // NOTE: only the valid bits are reset; the payload is never read while
    // its valid bit is clear, so it stays a plain reset-free register array.
    always_ff @(posedge clk_pixel) begin
        tbl_x_q     <= tbl_x_d;
        tbl_y_q     <= tbl_y_d;
        tbl_frame_q <= tbl_frame_d;
    end

    // ---------------------------------------------------------------------
    // Walk sequencer
    // ---------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [SW-1:0] idx_q, idx_d;
    logic [SW:0]   cnt_q, cnt_d;
    logic          restart_q, restart_d;  // boundary seen while a sprite was in flight
    logic [5:0]    prev_frame_q;
    logic [XW-1:0] sprite_x_q, sprite_x_d;
    logic [YW-1:0] sprite_y_q, sprite_y_d;
    logic [FW-1:0] sprite_frame_q, sprite_frame_d;
    logic [SW:0]   issued_q, issued_d;

    logic new_frame;
    logic eligible;
    logic last_slot;

    assign new_frame = (frame_count != prev_frame_q);
    assign last_slot = (idx_q == LAST_SLOT);

`ifdef SPRITE_CULL_EN
    assign eligible = tbl_active_q[idx_q]
                   && ({1'b0, tbl_x_q[idx_q]} < (XW+1)'(CANVAS_WIDTH))
                   && ({1'b0, tbl_y_q[idx_q]} < (YW+1)'(CANVAS_HEIGHT));
`else
    assign eligible = tbl_active_q[idx_q];
`endif

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        restart_d      = restart_q;
        sprite_x_d     = sprite_x_q;
        sprite_y_d     = sprite_y_q;
        sprite_frame_d = sprite_frame_q;
        issued_d       = issued_q;

        unique case (state_q)
            S_IDLE: begin
                if (new_frame) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end
            end

            S_SCAN: begin
                if (new_frame) begin
                    // Nothing in flight: restart the walk immediately.
                    idx_d = '0;
                    cnt_d = '0;
                end else if (eligible) begin
                    sprite_x_d     = tbl_x_q[idx_q];
                    sprite_y_d     = tbl_y_q[idx_q];
                    sprite_frame_d = tbl_frame_q[idx_q];
                    state_d        = S_ISSUE;
                end else if (last_slot) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_ISSUE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = S_ACK;
                if (new_frame) restart_d = 1'b1;
            end

            // The engine drops ready only after accepting, so ready is not
            // trusted in the cycle right after the request.
            S_ACK: begin
                state_d = S_WAIT;
                if (new_frame) restart_d = 1'b1;
            end

            S_WAIT: begin
                if (new_frame) restart_d = 1'b1;
                if (sprite_ready) begin
                    if (restart_q || new_frame) begin
                        // In-flight sprite finished; abandon the rest of the
                        // old walk without a walk_done.
                        idx_d     = '0;
                        cnt_d     = '0;
                        restart_d = 1'b0;
                        state_d   = S_SCAN;
                    end else if (last_slot) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SCAN;
                    end
                end
            end

            S_DONE: begin
                issued_d = cnt_q;
                if (new_frame) begin
                    // The walk did complete; the new boundary starts the
                    // next one without passing through IDLE.
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            restart_q      <= 1'b0;
            prev_frame_q   <= '0;
            sprite_x_q     <= '0;
            sprite_y_q     <= '0;
            sprite_frame_q <= '0;
            issued_q       <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            restart_q      <= restart_d;
            prev_frame_q   <= frame_count;
            sprite_x_q     <= sprite_x_d;
            sprite_y_q     <= sprite_y_d;
            sprite_frame_q <= sprite_frame_d;
            issued_q       <= issued_d;
        end
    end

    assign sprite_valid        = (state_q == S_ISSUE);
    assign walk_done           = (state_q == S_DONE);
    assign busy                = (state_q != S_IDLE);
    assign overrun             = new_frame && (state_q != S_IDLE);
    assign sprite_x            = sprite_x_q;
    assign sprite_y            = sprite_y_q;
    assign sprite_frame_number = sprite_frame_q;
    assign sprites_issued      = issued_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sprite_scheduler
//
// Self-checking bench for sprite_scheduler. A reference model holds its own
// copy of the sprite table; at each frame boundary it lists the eligible
// slots in ascending order and queues the expected requests followed by the
// expected walk completion. A monitor on the opposite clock edge pops and
// compares whenever the design pulses sprite_valid or walk_done. A simple
// graphics-engine model answers the handshake with a configurable delay.
// ---------------------------------------------------------------------------
module tb_sprite_scheduler;

    localparam int NS = 16;
    localparam int SW = 4;
    localparam int XW = 9;
    localparam int YW = 10;
    localparam int FW = 5;

    logic          clk_pixel = 1'b0;
    logic          sys_rst_n;
    logic [5:0]    frame_count;
    logic          wr_en;
    logic [SW-1:0] wr_slot;
    logic          wr_active;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [FW-1:0] wr_frame;
    logic          sprite_ready;
    logic          sprite_valid;
    logic [XW-1:0] sprite_x;
    logic [YW-1:0] sprite_y;
    logic [FW-1:0] sprite_frame_number;
    logic          busy;
    logic          walk_done;
    logic          overrun;
    logic [SW:0]   sprites_issued;

    sprite_scheduler dut (
        .clk_pixel           (clk_pixel),
        .sys_rst_n           (sys_rst_n),
        .frame_count         (frame_count),
        .wr_en               (wr_en),
        .wr_slot             (wr_slot),
        .wr_active           (wr_active),
        .wr_x                (wr_x),
        .wr_y                (wr_y),
        .wr_frame            (wr_frame),
        .sprite_ready        (sprite_ready),
        .sprite_valid        (sprite_valid),
        .sprite_x            (sprite_x),
        .sprite_y            (sprite_y),
        .sprite_frame_number (sprite_frame_number),
        .busy                (busy),
        .walk_done           (walk_done),
        .overrun             (overrun),
        .sprites_issued      (sprites_issued)
    );

    always #5 clk_pixel = ~clk_pixel;

    int cyc = 0;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit            is_done;
        int            slot;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [FW-1:0] f;
        int            cnt;
    } exp_t;

    exp_t          exp_q[$];
    bit            m_active [NS];
    logic [XW-1:0] m_x      [NS];
    logic [YW-1:0] m_y      [NS];
    logic [FW-1:0] m_f      [NS];
    int            ovr_exp = 0;
    int            boundary_cyc = 0;
    int            last_issued = 0;

    function automatic bit elig(input int s);
`ifdef SPRITE_CULL_EN
        return m_active[s] && (int'(m_x[s]) < 360) && (int'(m_y[s]) < 720);
`else
        return m_active[s];
`endif
    endfunction

    function automatic void push_walk();
        exp_t e;
        int   c = 0;
        for (int s = 0; s < NS; s++) begin
            if (elig(s)) begin
                e.is_done = 1'b0; e.slot = s; e.x = m_x[s]; e.y = m_y[s]; e.f = m_f[s]; e.cnt = 0;
                exp_q.push_back(e);
                c++;
            end
        end
        e.is_done = 1'b1; e.slot = -1; e.x = '0; e.y = '0; e.f = '0; e.cnt = c;
        exp_q.push_back(e);
    endfunction

    // ---------------- engine model ----------------
    int engine_delay = 1;
    bit engine_busy  = 1'b0;

    initial begin
        sprite_ready = 1'b1;
        forever begin
            @(negedge clk_pixel);
            if (sprite_valid) begin
                @(posedge clk_pixel); #1;
                engine_busy = 1'b1;            // ready stays high through the ACK cycle
                @(posedge clk_pixel); #1;
                sprite_ready = 1'b0;
                repeat (engine_delay) @(posedge clk_pixel);
                #1;
                sprite_ready = 1'b1;
                engine_busy  = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    int   valid_seen = 0;
    int   done_seen  = 0;
    int   ovr_seen   = 0;
    int   busy_seen  = 0;
    int   last_done_cyc = -1;
    int   vcyc_q[$];
    bit   chk_pending = 1'b0;
    int   issued_exp  = 0;

    always @(negedge clk_pixel) begin
        exp_t e;
        bit   have;
        if (chk_pending) begin
            check("sprites_issued", sprites_issued, issued_exp);
            last_issued = issued_exp;
            chk_pending = 1'b0;
        end
        if (busy) busy_seen++;
        if (overrun) ovr_seen++;
        if (sprite_valid) begin
            valid_seen++;
            vcyc_q.push_back(cyc);
            check("valid_while_engine_busy", engine_busy, 0);
            have = (exp_q.size() > 0) && !exp_q[0].is_done;
            check("valid_expected", have, 1);
            if (have) begin
                e = exp_q.pop_front();
                check($sformatf("sprite slot%0d x/y/frame", e.slot),
                      {sprite_x, sprite_y, sprite_frame_number}, {e.x, e.y, e.f});
            end
        end
        if (walk_done) begin
            done_seen++;
            last_done_cyc = cyc;
            have = (exp_q.size() > 0) && exp_q[0].is_done;
            check("walk_done_expected", have, 1);
            if (have) begin
                e = exp_q.pop_front();
                issued_exp  = e.cnt;
                chk_pending = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_slot(input int s, input bit act, input int x, input int y, input int f);
        @(posedge clk_pixel); #1;
        wr_en = 1'b1; wr_slot = SW'(s); wr_active = act;
        wr_x = XW'(x); wr_y = YW'(y); wr_frame = FW'(f);
        m_active[s] = act; m_x[s] = XW'(x); m_y[s] = YW'(y); m_f[s] = FW'(f);
        @(posedge clk_pixel); #1;
        wr_en = 1'b0;
    endtask

    task automatic change_frame(input logic [5:0] v);
        bit was_active;
        @(posedge clk_pixel); #1;
        frame_count  = v;
        boundary_cyc = cyc;
        was_active   = (exp_q.size() != 0);
        if (was_active) begin
            ovr_exp++;
            exp_q.delete();
        end
        push_walk();
        @(negedge clk_pixel);
        check("overrun_at_boundary", overrun, was_active);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || chk_pending || engine_busy) && n < budget) begin
            @(posedge clk_pixel);
            n++;
        end
        check("wait_idle_pending_expectations", exp_q.size(), 0);
        repeat (2) @(posedge clk_pixel);
    endtask

    task automatic wait_valids(input int target, input int budget);
        int n = 0;
        while (valid_seen < target && n < budget) begin
            @(posedge clk_pixel);
            n++;
        end
        check("wait_valid_reached", (valid_seen >= target), 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int v0, d0, o0, b0, li;
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, d0, bc;
        sys_rst_n = 1'b0; frame_count = '0;
        wr_en = 1'b0; wr_slot = '0; wr_active = 1'b0; wr_x = '0; wr_y = '0; wr_frame = '0;
        for (int s = 0; s < NS; s++) begin
            m_active[s] = 1'b0; m_x[s] = '0; m_y[s] = '0; m_f[s] = '0;
        end

        // Reset with frame_count held at 0
        repeat (3) @(posedge clk_pixel);
        #1 sys_rst_n = 1'b1;
        @(negedge clk_pixel);
        check("reset sprite_valid", sprite_valid, 0);
        check("reset busy", busy, 0);
        check("reset walk_done", walk_done, 0);
        check("reset overrun", overrun, 0);
        check("reset sprite_x", sprite_x, 0);
        check("reset sprite_y", sprite_y, 0);
        check("reset sprite_frame_number", sprite_frame_number, 0);
        check("reset sprites_issued", sprites_issued, 0);
        repeat (100) @(posedge clk_pixel);
        check("idle 100 cycles valid count", valid_seen, 0);
        check("idle 100 cycles busy count", busy_seen, 0);

        // Slots 2 and 5, slow engine
        write_slot(2, 1, 100, 50, 3);
        write_slot(5, 1, 200, 600, 17);
        engine_delay = 20;
        vcyc_q.delete();
        change_frame(6'd1);
        bc = boundary_cyc;
        wait_idle(500);
        check("slots 2,5 request count", vcyc_q.size(), 2);
        if (vcyc_q.size() > 0) check("first request latency", vcyc_q[0], bc + 4);
        check("slots 2,5 sprites_issued", sprites_issued, 2);

        // Empty table
        engine_delay = 2;
        change_frame(6'd3);
        wait_idle(500);
        write_slot(2, 0, 0, 0, 0);
        write_slot(5, 0, 0, 0, 0);
        v0 = valid_seen;
        change_frame(6'd4);
        bc = boundary_cyc;
        wait_idle(500);
        check("empty walk_done cycle", last_done_cyc, bc + 17);
        check("empty walk no requests", valid_seen, v0);
        check("empty sprites_issued", sprites_issued, 0);

        // Write to slot 7 in the cycle it is scanned
        write_slot(7, 1, 100, 200, 3);
        change_frame(6'd5);
        repeat (7) @(posedge clk_pixel);
        write_slot(7, 1, 10, 30, 9);     // lands in cycle boundary+8
        wait_idle(500);
        change_frame(6'd6);              // new contents on this walk
        wait_idle(500);

        // Off-canvas entry
        write_slot(7, 0, 0, 0, 0);
        write_slot(0, 1, 400, 100, 1);
        write_slot(1, 1, 10, 20, 2);
        change_frame(6'd7);
        wait_idle(500);
`ifdef SPRITE_CULL_EN
        check("cull sprites_issued", sprites_issued, 1);
`else
        check("no-cull sprites_issued", sprites_issued, 2);
`endif

        // Overrun during the slot 1 draw
        for (int s = 0; s < NS; s++)
            write_slot(s, 1, $urandom_range(0, 359), $urandom_range(0, 719), $urandom_range(0, 17));
        engine_delay = 4096;
        v0 = valid_seen; d0 = done_seen;
        change_frame(6'd8);
        wait_valids(v0 + 2, 10000);
        repeat (100) @(posedge clk_pixel);
        engine_delay = 3;
        change_frame(6'd9);              // queue now expects slot 0 next
        wait_valids(v0 + 3, 10000);
        check("aborted walk leaves sprites_issued", sprites_issued, last_issued);
        wait_idle(20000);
        check("one walk_done across overrun", done_seen, d0 + 1);
        check("overrun pulse count", ovr_seen, ovr_exp);

        // Randomized walks
        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 6; w++)
                write_slot($urandom_range(0, NS - 1), 1'($urandom_range(0, 1)),
                           $urandom_range(0, 511), $urandom_range(0, 1023), $urandom_range(0, 17));
            engine_delay = $urandom_range(0, 6);
            change_frame(frame_count + 6'($urandom_range(1, 62)));
            wait_idle(3000);
        end

        // Reset mid-walk
        for (int s = 0; s < 4; s++) write_slot(s, 1, 5 * s, 7 * s, s);
        engine_delay = 30;
        v0 = valid_seen;
        change_frame(frame_count + 6'd1);
        wait_valids(v0 + 1, 1000);
        repeat (5) @(posedge clk_pixel);
        #1;
        sys_rst_n = 1'b0;
        frame_count = '0;
        exp_q.delete();
        chk_pending = 1'b0;
        for (int s = 0; s < NS; s++) m_active[s] = 1'b0;
        repeat (3) @(posedge clk_pixel);
        #1 sys_rst_n = 1'b1;
        v0 = valid_seen; d0 = done_seen;
        repeat (50) @(posedge clk_pixel);
        @(negedge clk_pixel);
        check("post-reset no requests", valid_seen, v0);
        check("post-reset no walk_done", done_seen, d0);
        check("post-reset busy", busy, 0);
        check("post-reset sprites_issued", sprites_issued, 0);
        change_frame(6'd1);              // table was cleared by reset
        wait_idle(500);
        check("final overrun pulse count", ovr_seen, ovr_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
